// File: rtl/cim_pkg.sv
// cim_pkg: shared types and helpers for the CIM output-buffer controller.
package cim_pkg;

    typedef enum logic [1:0] {IDLE, READ, DRAIN, START} obuf_state_e;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

    function automatic logic signed [63:0] saturate(input logic signed [63:0] x, input int w);
        logic signed [63:0] hi, lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        return x > hi ? hi : x < lo ? lo : x;
    endfunction

endpackage

// File: rtl/cim_requant.sv
// cim_requant: sums one column across vertical tiles, shifts and saturates it.
// CIM_OBUF_RELU_EN additionally clamps negative results to zero.
module cim_requant
    import cim_pkg::*;
#(
    parameter int datatype_size = 8,
    parameter int acc_size      = 24,
    parameter int v_cim_tiles   = 1,
    parameter int out_shift     = 4
) (
    input  logic [v_cim_tiles-1:0][acc_size-1:0] col_i,
    output logic [datatype_size-1:0]             q_o
);
    localparam int sum_w = acc_size + $clog2(v_cim_tiles) + 1;

    logic signed [sum_w-1:0] sum;
    logic signed [sum_w-1:0] shifted;
    logic signed [63:0]      sat;

    always_comb begin
        sum = '0;
        for (int v = 0; v < v_cim_tiles; v++)
            sum = sum + {{(sum_w - acc_size){col_i[v][acc_size-1]}}, col_i[v]};
    end

    assign shifted = sum >>> out_shift;
    assign sat     = saturate(64'(shifted), datatype_size);

`ifdef CIM_OBUF_RELU_EN
    assign q_o = sat < 0 ? '0 : sat[datatype_size-1:0];
`else
    assign q_o = sat[datatype_size-1:0];
`endif

endmodule

// File: rtl/cim_obuf_ctrl.sv
// cim_obuf_ctrl: sweeps crossbar columns after CIM completes, requantizes into an
// output bank and hands it downstream via start/busy. Optional CIM_OBUF_RELU_EN.
module cim_obuf_ctrl
    import cim_pkg::*;
#(
    parameter int datatype_size = 8,
    parameter int acc_size      = 24,
    parameter int input_size    = 201,
    parameter int output_size   = 512,
    parameter int xbar_size     = 256,
    parameter int out_shift     = 4,
    parameter int v_cim_tiles   = ceil_div(input_size, xbar_size),
    parameter int h_cim_tiles   = ceil_div(output_size, xbar_size)
) (
    input  logic                                              clk,
    input  logic                                              rst,
    input  logic                                              i_cim_valid,
    output logic                                              o_busy,
    output logic                                              o_cim_re,
    output logic [$clog2(xbar_size):0]                        o_cim_addr,
    input  logic [v_cim_tiles*h_cim_tiles-1:0][acc_size-1:0]  i_cim_data,
    input  logic                                              i_next_busy,
    output logic                                              o_start,
    output logic [output_size-1:0][datatype_size-1:0]         o_data
);
    localparam int aw         = $clog2(xbar_size) + 1;
    localparam int read_limit = h_cim_tiles > 1 ? xbar_size : output_size;
    localparam logic [aw-1:0] last = aw'(read_limit - 1);

    obuf_state_e state_q, state_d;
    logic [aw-1:0] cnt_q, cnt_d, addr_q;
    logic          start_q, start_d, re_q;
    logic [output_size-1:0][datatype_size-1:0] data_q;
    logic [h_cim_tiles-1:0][datatype_size-1:0] q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            start_q <= start_d;
        end
    end

    // start is held until downstream raises busy after seeing it
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        start_d = start_q;
        case (state_q)
            IDLE:  state_d = i_cim_valid ? READ : IDLE;
            READ: begin
                cnt_d   = cnt_q == last ? '0 : cnt_q + aw'(1);
                state_d = cnt_q == last ? DRAIN : READ;
            end
            DRAIN: begin
                state_d = START;
                start_d = !i_next_busy;
            end
            START: begin
                state_d = start_q && i_next_busy ? IDLE : START;
                start_d = !i_next_busy;
            end
            default: state_d = IDLE;
        endcase
    end

    assign o_busy     = state_q == READ || state_q == DRAIN;
    assign o_cim_re   = state_q == READ;
    assign o_cim_addr = cnt_q;
    assign o_start    = start_q;
    assign o_data     = data_q;

    for (genvar h = 0; h < h_cim_tiles; h++) begin : g_rq
        logic [v_cim_tiles-1:0][acc_size-1:0] col;
        for (genvar v = 0; v < v_cim_tiles; v++) begin : g_col
            assign col[v] = i_cim_data[v*h_cim_tiles+h];
        end
        cim_requant #(
            .datatype_size(datatype_size),
            .acc_size     (acc_size),
            .v_cim_tiles  (v_cim_tiles),
            .out_shift    (out_shift)
        ) u_rq (
            .col_i(col),
            .q_o  (q[h])
        );
    end

    // returned words land one cycle after the read; out-of-range columns have no slot
    always_ff @(posedge clk) begin
        if (rst) begin
            re_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            re_q   <= o_cim_re;
            addr_q <= cnt_q;
            for (int i = 0; i < output_size; i++)
                if (re_q && addr_q == aw'(i % xbar_size))
                    data_q[i] <= q[i / xbar_size];
        end
    end

endmodule
